// File: rtl/seq_event_monitor.sv
// Counts rising edges of an upstream detect flag in BCD and tracks run lengths.
// Locks with a latched alarm once the event count reaches THRESH.
module seq_event_monitor #(
   parameter int THRESH = 10,
   parameter int RUN_W  = 4
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             en,
   input  logic             clr,
   input  logic             z_in,
   output logic             event_pulse,
   output logic [7:0]       event_bcd,
   output logic [RUN_W-1:0] run_len,
   output logic [RUN_W-1:0] max_run,
   output logic             alarm
);

   localparam logic [7:0] THRESH_BCD =
      8'(((THRESH / 10) % 10) * 16 + (THRESH % 10));
   localparam logic [RUN_W-1:0] RUN_MAX = '1;
   localparam bit LOCK_EN = (THRESH != 0);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      LOCK = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic             pulse_d;
   logic [7:0]       bcd_d, bcd_inc;
   logic [RUN_W-1:0] run_d, max_d;
   logic             alarm_d;

   // Saturating two-digit BCD increment
   always_comb begin
      bcd_inc = event_bcd;
      if (event_bcd == 8'h99)
         bcd_inc = 8'h99;
      else if (event_bcd[3:0] == 4'd9)
         bcd_inc = {event_bcd[7:4] + 4'd1, 4'd0};
      else
         bcd_inc = {event_bcd[7:4], event_bcd[3:0] + 4'd1};
   end

   always_comb begin
      state_d = state_q;
      pulse_d = 1'b0;
      bcd_d   = event_bcd;
      run_d   = run_len;
      max_d   = max_run;
      alarm_d = alarm;
      if (clr) begin
         state_d = IDLE;
         bcd_d   = 8'h00;
         run_d   = '0;
         max_d   = '0;
         alarm_d = 1'b0;
      end else if (en) begin
         unique case (state_q)
            IDLE: begin
               if (z_in) begin
                  pulse_d = 1'b1;
                  bcd_d   = bcd_inc;
                  run_d   = RUN_W'(1);
                  if (LOCK_EN && bcd_inc == THRESH_BCD) begin
                     state_d = LOCK;
                     alarm_d = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end else begin
                  run_d = '0;
               end
            end
            RUN: begin
               if (z_in) begin
                  if (run_len != RUN_MAX)
                     run_d = run_len + RUN_W'(1);
               end else begin
                  state_d = IDLE;
                  run_d   = '0;
               end
            end
            LOCK: begin
               alarm_d = 1'b1;
            end
            default: begin
               state_d = IDLE;
               alarm_d = 1'b0;
            end
         endcase
         // max tracks the run length written on this same edge
         if (run_d > max_run)
            max_d = run_d;
      end
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state_q     <= IDLE;
         event_pulse <= 1'b0;
         event_bcd   <= 8'h00;
         run_len     <= '0;
         max_run     <= '0;
         alarm       <= 1'b0;
      end else begin
         state_q     <= state_d;
         event_pulse <= pulse_d;
         event_bcd   <= bcd_d;
         run_len     <= run_d;
         max_run     <= max_d;
         alarm       <= alarm_d;
      end
   end

endmodule

// File: tb/tb_seq_event_monitor.sv
// Bench for seq_event_monitor: vector table, corner sequences, random vs model.
// Two instances cover THRESH=10 and THRESH=0 with shared stimulus.
module tb_seq_event_monitor;

   logic clk = 1'b0;
   logic aclr, en, clr, z;
   always #5 clk = ~clk;

   logic       p10, al10, p0, al0;
   logic [7:0] bcd10, bcd0;
   logic [3:0] run10, mx10, run0, mx0;

   seq_event_monitor #(.THRESH(10), .RUN_W(4)) u10 (
      .clk(clk), .aclr(aclr), .en(en), .clr(clr), .z_in(z),
      .event_pulse(p10), .event_bcd(bcd10), .run_len(run10),
      .max_run(mx10), .alarm(al10)
   );

   seq_event_monitor #(.THRESH(0), .RUN_W(4)) u0 (
      .clk(clk), .aclr(aclr), .en(en), .clr(clr), .z_in(z),
      .event_pulse(p0), .event_bcd(bcd0), .run_len(run0),
      .max_run(mx0), .alarm(al0)
   );

   // Model: event count as an integer, run as "previous accepted sample was 1"
   typedef struct {
      int cnt;
      bit locked;
      bit in_run;
      int run;
      int mx;
      bit pulse;
   } mdl_t;

   mdl_t md10, md0;
   int checks = 0;
   int errors = 0;

   function automatic mdl_t mreset();
      mdl_t m;
      m.cnt = 0; m.locked = 0; m.in_run = 0;
      m.run = 0; m.mx = 0; m.pulse = 0;
      return m;
   endfunction

   function automatic mdl_t step(mdl_t m, int thresh, bit e, bit c, bit zz);
      m.pulse = 0;
      if (c) return mreset();
      if (!e || m.locked) return m;
      if (zz && !m.in_run) begin
         m.cnt = (m.cnt >= 99) ? 99 : m.cnt + 1;
         m.pulse = 1;
         m.run = 1;
         m.in_run = 1;
         if (thresh != 0 && m.cnt == thresh) m.locked = 1;
      end else if (zz) begin
         m.run = (m.run >= 15) ? 15 : m.run + 1;
      end else begin
         m.run = 0;
         m.in_run = 0;
      end
      if (m.run > m.mx) m.mx = m.run;
      return m;
   endfunction

   function automatic logic [17:0] mexp(mdl_t m);
      logic [7:0] b;
      b = 8'((m.cnt / 10) * 16 + (m.cnt % 10));
      return {m.pulse, b, 4'(m.run), 4'(m.mx), m.locked};
   endfunction

   function automatic logic [17:0] pk10();
      return {p10, bcd10, run10, mx10, al10};
   endfunction

   function automatic logic [17:0] pk0();
      return {p0, bcd0, run0, mx0, al0};
   endfunction

   task automatic chk(string name, logic [17:0] act, logic [17:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      md10 = step(md10, 10, en, clr, z);
      md0  = step(md0, 0, en, clr, z);
      #1;
   endtask

   task automatic drive(bit e, bit c, bit zz);
      en = e; clr = c; z = zz;
      tick();
   endtask

   typedef struct {
      bit e;
      bit c;
      bit zz;
      logic [17:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit e, bit c, bit zz, logic [17:0] x);
      vec_t v;
      v.e = e; v.c = c; v.zz = zz; v.exp = x;
      return v;
   endfunction

   initial begin
      // Expected fields: {pulse, bcd, run, max, alarm} for THRESH=10
      tbl.push_back(mk(1, 1, 0, {1'b0, 8'h00, 4'd0, 4'd0, 1'b0}));
      tbl.push_back(mk(1, 0, 0, {1'b0, 8'h00, 4'd0, 4'd0, 1'b0}));
      tbl.push_back(mk(1, 0, 1, {1'b1, 8'h01, 4'd1, 4'd1, 1'b0}));
      tbl.push_back(mk(1, 0, 1, {1'b0, 8'h01, 4'd2, 4'd2, 1'b0}));
      tbl.push_back(mk(1, 0, 1, {1'b0, 8'h01, 4'd3, 4'd3, 1'b0}));
      tbl.push_back(mk(1, 0, 0, {1'b0, 8'h01, 4'd0, 4'd3, 1'b0}));
      tbl.push_back(mk(1, 0, 1, {1'b1, 8'h02, 4'd1, 4'd3, 1'b0}));
      tbl.push_back(mk(1, 0, 1, {1'b0, 8'h02, 4'd2, 4'd3, 1'b0}));
      tbl.push_back(mk(1, 0, 0, {1'b0, 8'h02, 4'd0, 4'd3, 1'b0}));
      tbl.push_back(mk(1, 0, 1, {1'b1, 8'h03, 4'd1, 4'd3, 1'b0}));
      tbl.push_back(mk(0, 0, 1, {1'b0, 8'h03, 4'd1, 4'd3, 1'b0}));
      tbl.push_back(mk(1, 0, 1, {1'b0, 8'h03, 4'd2, 4'd3, 1'b0}));
      tbl.push_back(mk(0, 0, 1, {1'b0, 8'h03, 4'd2, 4'd3, 1'b0}));
      tbl.push_back(mk(1, 0, 0, {1'b0, 8'h03, 4'd0, 4'd3, 1'b0}));
      tbl.push_back(mk(1, 1, 1, {1'b0, 8'h00, 4'd0, 4'd0, 1'b0}));
      tbl.push_back(mk(1, 0, 0, {1'b0, 8'h00, 4'd0, 4'd0, 1'b0}));

      aclr = 1'b0; en = 1'b0; clr = 1'b0; z = 1'b0;
      md10 = mreset(); md0 = mreset();
      #12;
      chk("reset_t10", pk10(), 18'h0);
      chk("reset_t0", pk0(), 18'h0);
      aclr = 1'b1;
      tick();

      foreach (tbl[i]) begin
         drive(tbl[i].e, tbl[i].c, tbl[i].zz);
         chk($sformatf("vec%0d", i), pk10(), tbl[i].exp);
      end

      // Asynchronous reset in the middle of a run
      drive(1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 1);
         drive(1, 0, 0);
      end
      for (int i = 0; i < 3; i++) drive(1, 0, 1);
      chk("pre_aclr", pk10(), {1'b0, 8'h05, 4'd3, 4'd3, 1'b0});
      #3 aclr = 1'b0;
      #1;
      chk("aclr_async_t10", pk10(), 18'h0);
      chk("aclr_async_t0", pk0(), 18'h0);
      md10 = mreset(); md0 = mreset();
      #2 aclr = 1'b1;
      drive(1, 0, 1);
      chk("post_aclr_idle", pk10(), {1'b1, 8'h01, 4'd1, 4'd1, 1'b0});

      // Threshold lock at ten events
      drive(1, 1, 0);
      for (int i = 0; i < 9; i++) begin
         drive(1, 0, 1);
         drive(1, 0, 0);
      end
      chk("nine_events", pk10(), {1'b0, 8'h09, 4'd0, 4'd1, 1'b0});
      drive(1, 0, 1);
      chk("tenth_lock", pk10(), {1'b1, 8'h10, 4'd1, 4'd1, 1'b1});
      drive(1, 0, 0);
      drive(1, 0, 1);
      chk("lock_frozen", pk10(), {1'b0, 8'h10, 4'd1, 4'd1, 1'b1});
      drive(1, 1, 0);
      chk("lock_clr", pk10(), 18'h0);

      // BCD saturation and run saturation with locking disabled
      for (int i = 0; i < 99; i++) begin
         drive(1, 0, 1);
         drive(1, 0, 0);
      end
      chk("bcd99", pk0(), {1'b0, 8'h99, 4'd0, 4'd1, 1'b0});
      drive(1, 0, 1);
      chk("bcd99_sat", pk0(), {1'b1, 8'h99, 4'd1, 4'd1, 1'b0});
      drive(1, 0, 0);
      for (int i = 0; i < 20; i++) drive(1, 0, 1);
      chk("run_sat", pk0(), {1'b0, 8'h99, 4'd15, 4'd15, 1'b0});
      chk("model_sync_t0", pk0(), mexp(md0));

      // Randomised stimulus against the model
      drive(1, 1, 0);
      for (int i = 0; i < 3000; i++) begin
         bit zz;
         zz = ($urandom_range(0, 99) < 30) ? ~z : z;
         drive($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 2, zz);
         chk("rand_t10", pk10(), mexp(md10));
         chk("rand_t0", pk0(), mexp(md0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_event_monitor.md
Name: seq_event_monitor

Overview:
- Downstream consumer of the run-detector FSM's registered detect flag `z`.
- That FSM raises `z` after four equal consecutive bits on `w`, and holds it while the run continues.
- This block counts detection events (rising edges of `z`) in two BCD digits and measures the current and longest detect-run length in sampled cycles.
- Raises a latched alarm when the event count reaches a threshold. Outputs drive board LEDs/HEX decoders.

Parameters:
- THRESH, 10, event count (decimal, 0..99) at which the block locks and asserts alarm; 0 disables locking.
- RUN_W, 4, width of run_len/max_run counters (saturating at 2^RUN_W-1).

Ports:
- clk  input  1  system clock, rising edge
- aclr  input  1  asynchronous reset, active-low
- en  input  1  sample enable; state advances only on edges where en=1
- clr  input  1  synchronous clear, active-high, priority over en
- z_in  input  1  detect flag from the upstream run-detector, synchronous to clk
- event_pulse  output  1  one-cycle pulse per counted event
- event_bcd  output  8  event count, [7:4] tens, [3:0] units, BCD
- run_len  output  RUN_W  length of current detect run, in samples
- max_run  output  RUN_W  longest run since reset/clear
- alarm  output  1  high while in LOCK

Behaviour:
- Reset (aclr=0, async): state=IDLE; event_pulse=0, event_bcd=8'h00, run_len=0, max_run=0, alarm=0.
- clr=1 at an edge: same values as reset, regardless of en or state.
- en=0 and clr=0: all registers hold; event_pulse forced 0 on that edge.
- All outputs are registered. An input sampled at edge k is visible after edge k (latency 1).
- FSM states, evaluated only on edges with en=1, clr=0:
  - IDLE, z_in=0: stay; run_len=0.
  - IDLE, z_in=1: go to RUN; run_len=1; event_pulse=1; event_bcd increments.
  - RUN, z_in=1: stay; run_len increments, saturating at 2^RUN_W-1.
  - RUN, z_in=0: go to IDLE; run_len=0; max_run keeps its value.
  - LOCK: z_in ignored; event_bcd, run_len and max_run frozen; event_pulse=0; alarm=1. LOCK is left only by clr or aclr.
- max_run: on every edge where run_len is written, max_run <= max(max_run, new run_len). This is the same edge, so max_run never lags run_len.
- event_bcd increment:
  - Units 9 wraps to 0 and carries into tens.
  - At 99 the count saturates (stays 99) and event_pulse is still asserted.
- Threshold (THRESH != 0): on the IDLE->RUN edge whose incremented count equals THRESH:
  - event_bcd=THRESH, event_pulse=1, run_len=1.
  - State goes to LOCK (not RUN); alarm=1 on the same edge.
- THRESH=0: LOCK is never entered and alarm stays 0.
- Simultaneous events:
  - clr beats en and z_in.
  - aclr beats everything.
  - A z_in rising edge coinciding with en=0 is not seen until the next en=1 sample, and only if z_in is still 1 then.
- Illegal state encodings recover to IDLE on the next enabled edge.

Test Plan:
1. aclr pulse low mid-run (state RUN, run_len=3, event_bcd=8'h05) -> all outputs 0 immediately, without waiting for a clock edge; state IDLE.
2. en=1; z_in pattern 0,1,1,1,0,1,1,0 -> event_pulse high after edges 2 and 6 only; event_bcd=8'h02; run_len sequence 0,1,2,3,0,1,2,0; max_run=3.
3. en toggling 1,0,1,0; z_in=1 held -> run_len advances only on en=1 edges; event_pulse asserts once.
4. THRESH=10: 10 separate one-sample z_in pulses, each followed by a 0 sample -> event_bcd goes 8'h09 then 8'h10, alarm=1 on the tenth event edge; further pulses leave event_bcd=8'h10 and event_pulse=0; clr=1 -> all outputs 0, state IDLE.
5. THRESH=0: 100 events -> event_bcd=8'h99 after the 99th event and stays 8'h99 after the 100th; event_pulse still pulses; alarm stays 0. Also z_in=1 held for 20 samples -> run_len and max_run saturate at 15.
6. clr=1 together with en=1, z_in rising -> no event counted, event_pulse=0, outputs 0.
